fetch_queue: RTL and testbench

//  Sits directly downstream of the Fetch PC stage. Accepts PCs, issues in-order

---
 rtl/fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_fetch_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: buffer between the Fetch PC stage and Decode.
//   Accepts PCs from Fetch, forwards each one as an in-order instruction-memory
//   read, stores returned instructions next to their PCs, and hands
//   {pc, inst} pairs to Decode. A flush discards every allocated entry. It also
//   discards every read still in flight, counting those reads in drop_cnt so
//   that their late responses are thrown away.
//
// Handshakes: every channel uses valid/ready. A transfer happens in a cycle
//   where valid && ready are both high. The imem response channel is the one
//   exception: it is valid-only, because memory cannot be back-pressured.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   pc_valid, pc, pc_ready        Fetch -> queue
//   flush                         mispredict redirect
//   imem_req_valid/addr/ready     queue -> instruction memory request
//   imem_resp_valid/data          instruction memory -> queue (in order)
//   dec_valid/pc/inst, dec_ready  queue -> Decode
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   Forwards a response straight to Decode in its arrival cycle when the queue
//   head is waiting for exactly that response.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  input  logic        dec_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head, fill, tail;
  logic [CW-1:0]    count, drop_cnt;

  logic [CW-1:0] filled_cnt;
  logic [CW-1:0] unfilled;
  logic [CW:0]   occupancy;
  logic [CW:0]   drop_flush_sum;
  logic          credit;
  logic          accept;
  logic          deq;
  logic          head_filled;
  logic          bypass_hit;
  logic          resp_write;
  logic          resp_drop;
  logic          fill_adv;
  logic [CW-1:0] count_next;

  // Count the filled flags, so that unfilled equals the number of reads this
  // queue still expects to land in its entries.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + {{(CW-1){1'b0}}, filled[i]};
    end
  end

  assign unfilled  = count - filled_cnt;
  // Reads dropped by a flush still occupy memory, so they consume credit too.
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
  assign credit    = occupancy < (CW+1)'(DEPTH);

  assign pc_ready       = !rst && imem_req_ready && credit && !flush;
  assign imem_req_valid = !rst && pc_valid && credit && !flush;
  assign imem_req_addr  = pc;
  assign accept         = pc_valid && pc_ready;

  assign head_filled = filled[head];

`ifdef FETCH_QUEUE_BYPASS_EN
  // The head is waiting on the very response arriving now.
  assign bypass_hit = !rst && (head == fill) && !head_filled && imem_resp_valid &&
                      (drop_cnt == '0) && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign dec_valid = !rst && ((head_filled && !flush) || bypass_hit);
  assign dec_pc    = pc_mem[head];
  assign dec_inst  = bypass_hit ? imem_resp_data : inst_mem[head];
  assign deq       = dec_valid && dec_ready;

  // A bypassed response that Decode takes at once never touches storage.
  assign resp_write = imem_resp_valid && !flush && (drop_cnt == '0) &&
                      !(bypass_hit && dec_ready);
  assign resp_drop  = imem_resp_valid && !flush && (drop_cnt != '0);
  assign fill_adv   = resp_write || (bypass_hit && dec_ready);

  // A response in the flush cycle belongs either to an older dropped read or
  // to the oldest unfilled entry. Either way it retires one outstanding read.
  assign drop_flush_sum = {1'b0, drop_cnt} + {1'b0, unfilled} -
                          {{CW{1'b0}}, imem_resp_valid};

  always_comb begin
    count_next = count;
    case ({accept, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (flush) begin
      head     <= tail;
      fill     <= tail;
      count    <= '0;
      filled   <= '0;
      drop_cnt <= drop_flush_sum[CW-1:0];
    end else begin
      if (accept) begin
        filled[tail] <= 1'b0;
        tail         <= tail + PW'(1);
      end
      if (resp_write) begin
        filled[fill] <= 1'b1;
      end
      if (fill_adv) begin
        fill <= fill + PW'(1);
      end
      if (deq) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      count <= count_next;
    end
  end

  // Payload storage needs no reset because the filled flags qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail] <= pc;
    end
    if (resp_write) begin
      inst_mem[fill] <= imem_resp_data;
    end
  end

  a_resp_outstanding: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((drop_cnt != '0) || (unfilled != '0)));

  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    occupancy <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_ready;

  fetch_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_valid        (pc_valid),
    .pc              (pc),
    .pc_ready        (pc_ready),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_pc          (dec_pc),
    .dec_inst        (dec_inst),
    .dec_ready       (dec_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic pc_valid;
    logic req_ready;
    logic flush;
    logic exp_req_valid;
    logic exp_pc_ready;
  } req_vec_t;

  logic [63:0] exp_q[$];
  mem_t        mem_q[$];
  int          acc_cyc_q[$];
  int          dec_cyc_q[$];
  int          cyc;
  int          mem_lat;
  logic        mem_en;
  int          checks;
  int          errors;
  req_vec_t    vecs[6];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hA0;
      32'h4:   return 32'hA4;
      32'h8:   return 32'hA8;
      32'h100: return 32'hB0;
      32'h20:  return 32'hC0;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: drives the head of the in-order response queue when due.
  task automatic drive_resp();
    if (mem_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_q[0].data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  // One clock cycle: sample at the falling edge, update models after the rising edge.
  task automatic step();
    logic sent;
    @(negedge clk);
    sent = 1'b0;
    if (!rst) begin
      sent = imem_resp_valid;
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{due: cyc + mem_lat, data: data_of(imem_req_addr)});
      end
      if (pc_valid && pc_ready) begin
        exp_q.push_back({pc, data_of(pc)});
        acc_cyc_q.push_back(cyc);
      end
      if (flush) exp_q.delete();
      if (dec_valid && dec_ready) begin
        dec_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_unexpected: got %0h/%0h expected no output", dec_pc, dec_inst);
        end else begin
          chk("dec_pair", {dec_pc, dec_inst}, exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (sent) void'(mem_q.pop_front());
    cyc++;
    drive_resp();
  endtask

  task automatic drain(input int n);
    pc_valid  = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b1;
    mem_en    = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      step();
    end
    chk("drain_done", 64'(exp_q.size() + mem_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mem_lat = 1; mem_en = 1'b1;
    rst = 1'b1; pc_valid = 1'b1; pc = 32'h0; flush = 1'b0;
    imem_req_ready = 1'b1; dec_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_rst_pc_ready", 64'(pc_ready), 64'd1);
    pc_valid = 1'b0;
    drive_resp();

    // Request path on a nearly empty queue
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc_valid       = vecs[i].pc_valid;
      imem_req_ready = vecs[i].req_ready;
      flush          = vecs[i].flush;
      pc             = $urandom & 32'hFFFF_FFFC;
      #1;
      chk("vec_req_valid", 64'(imem_req_valid), 64'(vecs[i].exp_req_valid));
      chk("vec_pc_ready", 64'(pc_ready), 64'(vecs[i].exp_pc_ready));
      chk("vec_req_addr", 64'(imem_req_addr), 64'(pc));
      step();
    end
    imem_req_ready = 1'b1;
    drain(40);

    // Stream 0x0, 0x4, 0x8 with memory latency 2
    mem_lat = 2;
    acc_cyc_q.delete(); dec_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc = 32'(i * 4);
      #1;
      chk("stream_pc_ready", 64'(pc_ready), 64'd1);
      step();
    end
    pc_valid = 1'b0;
    drain(40);
    chk("stream_count", 64'(dec_cyc_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < dec_cyc_q.size() && i < acc_cyc_q.size())
        chk("stream_latency", 64'(dec_cyc_q[i] - acc_cyc_q[i]), 64'(EXP_LAT));
    end

    // Full queue holds off the fifth PC until one dequeue
    mem_lat = 1; dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; pc = 32'h40 + 32'(i * 4);
      #1;
      chk("full_fill_ready", 64'(pc_ready), 64'd1);
      step();
    end
    pc = 32'h50;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_blocked", 64'(pc_ready), 64'd0);
      step();
    end
    dec_ready = 1'b1;
    #1;
    chk("full_deq_cycle_ready", 64'(pc_ready), 64'd0);
    chk("full_head_valid", 64'(dec_valid), 64'd1);
    step();
    dec_ready = 1'b0;
    #1;
    chk("full_after_deq_ready", 64'(pc_ready), 64'd1);
    step();
    drain(40);

    // Flush with two reads in flight
    mem_en = 1'b0; drive_resp(); dec_ready = 1'b1;
    dec_cyc_q.delete();
    pc_valid = 1'b1; pc = 32'h10; step();
    pc = 32'h14; step();
    pc_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_pc_ready", 64'(pc_ready), 64'd0);
    chk("flush_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    flush = 1'b0; pc_valid = 1'b1; pc = 32'h100;
    #1;
    chk("post_flush_ready", 64'(pc_ready), 64'd1);
    step();
    pc_valid = 1'b0;
    drain(40);
    chk("flush_dec_count", 64'(dec_cyc_q.size()), 64'd1);

    // Flush coincident with a response: two later responses dropped
    mem_en = 1'b0; drive_resp(); dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc = 32'h200 + 32'(i * 4); step();
    end
    pc_valid = 1'b0;
    mem_en = 1'b1; drive_resp();
    flush = 1'b1;
    step();
    flush = 1'b0; mem_en = 1'b0; drive_resp();
    dec_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc = 32'h300 + 32'(i * 4);
      #1;
      chk("drop_credit", 64'(pc_ready), (i < 2) ? 64'd1 : 64'd0);
      step();
    end
    pc_valid = 1'b0;
    drain(40);
    chk("drop_dec_count", 64'(dec_cyc_q.size()), 64'd2);

    // Response-to-decode bypass (or its absence)
    mem_lat = 1; dec_ready = 1'b1;
    pc_valid = 1'b1; pc = 32'h20;
    step();
    pc_valid = 1'b0;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_valid", 64'(dec_valid), 64'd1);
    chk("bypass_pair", {dec_pc, dec_inst}, {32'h20, 32'hC0});
`else
    chk("nobypass_valid", 64'(dec_valid), 64'd0);
    step();
    #1;
    chk("nobypass_next_valid", 64'(dec_valid), 64'd1);
    chk("nobypass_pair", {dec_pc, dec_inst}, {32'h20, 32'hC0});
`endif
    drain(40);

    // Random traffic with flushes, variable latency and backpressure
    for (int i = 0; i < 120; i++) begin
      pc_valid       = 1'($urandom_range(0, 1));
      pc             = $urandom & 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 19) == 0);
      mem_lat        = $urandom_range(1, 3);
      step();
    end
    imem_req_ready = 1'b1; mem_lat = 1;
    drain(200);

    // Reset in the middle of traffic
    pc_valid = 1'b1; pc = 32'h500; step();
    pc = 32'h504; step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pc_ready", 64'(pc_ready), 64'd0);
    chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("midrst_dec_valid", 64'(dec_valid), 64'd0);
    exp_q.delete(); mem_q.delete(); pc_valid = 1'b0;
    imem_resp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_resp();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_midrst_idle", 64'(dec_valid), 64'd0);
      step();
    end
    pc_valid = 1'b1; pc = 32'h400; step();
    pc_valid = 1'b0;
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
